// File: rtl/control_sequencer_if.sv
// Handshake and status bundle between the control sequencer and the CPU datapath.
// The sequencer uses the slave view; the datapath (or a bench) drives through master.
interface control_sequencer_if #(
  parameter int IR_W = 32
);
  logic            stop;
  logic [IR_W-1:0] ir;
  logic            mem_ready;
  logic            con_ff;
  logic [27:0]     ctrl;
  logic            run;
  logic [1:0]      err;
  logic [5:0]      state;

  modport master (output stop, ir, mem_ready, con_ff, input ctrl, run, err, state);
  modport slave  (input stop, ir, mem_ready, con_ff, output ctrl, run, err, state);
endinterface

// File: rtl/control_sequencer.sv
// Multi-cycle Moore control FSM for the bus CPU: fetch, opcode decode and one control
// word per clock, with memory-ready timeout, mul/div hold and branch-not-taken shortcut.
module control_sequencer #(
  parameter int IR_W       = 32,
  parameter int MD_CYCLES  = 1,
  parameter int WAIT_LIMIT = 16,
  parameter bit BR_SKIP    = 1'b1
) (
  input logic               clock,
  input logic               clear_n,
  control_sequencer_if.slave bus
);
  localparam logic [27:0]
    PCOUT = 28'd1 << 0,  ZHIGHOUT = 28'd1 << 1,  ZLOWOUT = 28'd1 << 2,  MDROUT = 28'd1 << 3,
    MARIN = 28'd1 << 4,  PCIN = 28'd1 << 5,      MDRIN = 28'd1 << 6,    IRIN = 28'd1 << 7,
    YIN = 28'd1 << 8,    INCPC = 28'd1 << 9,     READ = 28'd1 << 10,    HIIN = 28'd1 << 11,
    LOIN = 28'd1 << 12,  HIOUT = 28'd1 << 13,    LOOUT = 28'd1 << 14,   ZIN = 28'd1 << 15,
    COUT = 28'd1 << 16,  WRITE = 28'd1 << 17,    GRA = 28'd1 << 18,     GRB = 28'd1 << 19,
    GRC = 28'd1 << 20,   RIN = 28'd1 << 21,      ROUT = 28'd1 << 22,    BAOUT = 28'd1 << 23,
    CONIN = 28'd1 << 24, INPORTIN = 28'd1 << 25, OUTPORTIN = 28'd1 << 26,
    INPORTOUT = 28'd1 << 27;

  localparam logic [7:0] WAIT_LAST = 8'(WAIT_LIMIT - 1);
  localparam logic [7:0] MD_LAST   = 8'(MD_CYCLES - 1);

  typedef enum logic [5:0] {
    S_RESET, S_HALT, S_F0, S_F1, S_F2,
    S_ALU3, S_ALU4, S_ALU5, S_IMM3, S_IMM4, S_IMM5,
    S_MD3, S_MD4, S_MD5, S_MD6, S_NN3, S_NN4,
    S_LD3, S_LD4, S_LD5, S_LD6, S_LD7, S_LDI5, S_ST6, S_ST7,
    S_BR3, S_BR4, S_BR5, S_BR6, S_JR3, S_JAL3, S_JAL4,
    S_MFHI3, S_MFLO3, S_IN3, S_OUT3, S_NOP3
  } state_e;

  state_e      state_q, state_d, instr_end;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  err_q, err_d;
  logic [27:0] ctrl_w;
  logic [4:0]  opcode;
  logic        br_skip;
  logic        unused_ir_bits;

  assign opcode         = bus.ir[IR_W-1 -: 5];
  assign unused_ir_bits = ^bus.ir[IR_W-6:0];
  assign br_skip        = BR_SKIP && !bus.con_ff;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= S_RESET;
      cnt_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // One counter serves both memory-wait and mul/div hold; it clears whenever the state moves.
  always_comb begin
    instr_end = bus.stop ? S_HALT : S_F0;
    state_d   = state_q;
    cnt_d     = '0;
    err_d     = err_q;
    case (state_q)
      S_RESET: state_d = S_F0;
      S_F0:    state_d = S_F1;
      S_F1, S_LD6, S_ST7: begin
        if (bus.mem_ready)
          state_d = (state_q == S_F1) ? S_F2 : (state_q == S_LD6) ? S_LD7 : instr_end;
        else if (cnt_q == WAIT_LAST) begin
          state_d  = S_HALT;
          err_d[1] = 1'b1;
        end else
          cnt_d = sat_inc(cnt_q);
      end
      S_F2: begin
        case (opcode) inside
          [5'd0:5'd2]:   state_d = S_LD3;
          [5'd3:5'd11]:  state_d = S_ALU3;
          [5'd12:5'd14]: state_d = S_IMM3;
          5'd15, 5'd16:  state_d = S_MD3;
          5'd17, 5'd18:  state_d = S_NN3;
          5'd19:         state_d = S_BR3;
          5'd20:         state_d = S_JR3;
          5'd21:         state_d = S_JAL3;
          5'd22:         state_d = S_IN3;
          5'd23:         state_d = S_OUT3;
          5'd24:         state_d = S_MFHI3;
          5'd25:         state_d = S_MFLO3;
          5'd26:         state_d = S_NOP3;
          5'd27:         state_d = S_HALT;
          default: begin
            state_d  = S_HALT;
            err_d[0] = 1'b1;
          end
        endcase
      end
      S_ALU3: state_d = S_ALU4;
      S_ALU4: state_d = S_ALU5;
      S_IMM3: state_d = S_IMM4;
      S_IMM4: state_d = S_IMM5;
      S_MD3:  state_d = S_MD4;
      S_MD4: begin
        if (cnt_q == MD_LAST) state_d = S_MD5;
        else                  cnt_d   = sat_inc(cnt_q);
      end
      S_MD5:  state_d = S_MD6;
      S_NN3:  state_d = S_NN4;
      S_LD3:  state_d = S_LD4;
      S_LD4:  state_d = (opcode == 5'd1) ? S_LDI5 : S_LD5;
      S_LD5:  state_d = (opcode == 5'd2) ? S_ST6 : S_LD6;
      S_ST6:  state_d = S_ST7;
      S_BR3:  state_d = S_BR4;
      S_BR4:  state_d = br_skip ? instr_end : S_BR5;
      S_BR5:  state_d = S_BR6;
      S_JAL3: state_d = S_JAL4;
      S_ALU5, S_IMM5, S_MD6, S_NN4, S_LD7, S_LDI5, S_BR6, S_JR3, S_JAL4,
      S_MFHI3, S_MFLO3, S_IN3, S_OUT3, S_NOP3: state_d = instr_end;
      default: state_d = S_HALT;
    endcase
  end

  // con_ff is itself a flop set by CONin in T3, so gating the T4 word keeps outputs glitch-free.
  always_comb begin
    ctrl_w = '0;
    case (state_q)
      S_F0:    ctrl_w = PCOUT | MARIN | INCPC | ZIN;
      S_F1:    ctrl_w = ZLOWOUT | PCIN | READ | MDRIN;
      S_F2:    ctrl_w = MDROUT | IRIN;
      S_ALU3:  ctrl_w = GRB | ROUT | YIN;
      S_ALU4:  ctrl_w = GRC | ROUT | ZIN;
      S_ALU5:  ctrl_w = GRA | RIN | ZLOWOUT;
      S_IMM3:  ctrl_w = GRB | ROUT | YIN;
      S_IMM4:  ctrl_w = COUT | ZIN;
      S_IMM5:  ctrl_w = GRA | RIN | ZLOWOUT;
      S_MD3:   ctrl_w = GRA | ROUT | YIN;
      S_MD4:   ctrl_w = GRB | ROUT | ZIN;
      S_MD5:   ctrl_w = LOIN | ZLOWOUT;
      S_MD6:   ctrl_w = HIIN | ZHIGHOUT;
      S_NN3:   ctrl_w = GRB | ROUT | ZIN;
      S_NN4:   ctrl_w = GRA | RIN | ZLOWOUT;
      S_LD3:   ctrl_w = GRB | BAOUT | YIN;
      S_LD4:   ctrl_w = COUT | ZIN;
      S_LD5:   ctrl_w = ZLOWOUT | MARIN;
      S_LD6:   ctrl_w = READ | MDRIN;
      S_LD7:   ctrl_w = MDROUT | GRA | RIN;
      S_LDI5:  ctrl_w = ZLOWOUT | GRA | RIN;
      S_ST6:   ctrl_w = GRA | ROUT | MDRIN;
      S_ST7:   ctrl_w = WRITE;
      S_BR3:   ctrl_w = GRA | ROUT | CONIN;
      S_BR4:   ctrl_w = br_skip ? 28'd0 : (PCOUT | YIN);
      S_BR5:   ctrl_w = COUT | ZIN;
      S_BR6:   ctrl_w = ZLOWOUT | PCIN;
      S_JR3:   ctrl_w = GRA | ROUT | PCIN;
      S_JAL3:  ctrl_w = PCOUT | GRB | RIN;
      S_JAL4:  ctrl_w = GRA | ROUT | PCIN;
      S_MFHI3: ctrl_w = GRA | RIN | HIOUT;
      S_MFLO3: ctrl_w = GRA | RIN | LOOUT;
      S_IN3:   ctrl_w = GRA | RIN | INPORTOUT;
      S_OUT3:  ctrl_w = GRA | ROUT | OUTPORTIN;
      default: ctrl_w = '0;
    endcase
  end

  assign bus.ctrl  = ctrl_w;
  assign bus.run   = (state_q != S_RESET) && (state_q != S_HALT);
  assign bus.err   = err_q;
  assign bus.state = state_q;
endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: opcode table, scripted corner sequences and random
// instruction streams checked against a microprogram list built from the opcode rules.
module tb_control_sequencer;
  localparam int MD_CYCLES = 4;
  localparam logic [27:0]
    PCOUT = 28'd1 << 0,  ZHIGHOUT = 28'd1 << 1,  ZLOWOUT = 28'd1 << 2,  MDROUT = 28'd1 << 3,
    MARIN = 28'd1 << 4,  PCIN = 28'd1 << 5,      MDRIN = 28'd1 << 6,    IRIN = 28'd1 << 7,
    YIN = 28'd1 << 8,    INCPC = 28'd1 << 9,     READ = 28'd1 << 10,    HIIN = 28'd1 << 11,
    LOIN = 28'd1 << 12,  HIOUT = 28'd1 << 13,    LOOUT = 28'd1 << 14,   ZIN = 28'd1 << 15,
    COUT = 28'd1 << 16,  WRITE = 28'd1 << 17,    GRA = 28'd1 << 18,     GRB = 28'd1 << 19,
    GRC = 28'd1 << 20,   RIN = 28'd1 << 21,      ROUT = 28'd1 << 22,    BAOUT = 28'd1 << 23,
    CONIN = 28'd1 << 24, INPORTIN = 28'd1 << 25, OUTPORTIN = 28'd1 << 26,
    INPORTOUT = 28'd1 << 27;
  localparam logic [27:0] F0W = PCOUT | MARIN | INCPC | ZIN;
  localparam logic [27:0] F1W = ZLOWOUT | PCIN | READ | MDRIN;
  localparam logic [27:0] F2W = MDROUT | IRIN;

  logic clock = 1'b0;
  logic clear_n;
  always #5 clock = ~clock;

  control_sequencer_if #(.IR_W(32)) bus ();
  control_sequencer #(.IR_W(32), .MD_CYCLES(MD_CYCLES), .WAIT_LIMIT(16), .BR_SKIP(1'b1)) dut (
    .clock(clock), .clear_n(clear_n), .bus(bus));

  int checks = 0;
  int errors = 0;

  typedef struct packed { logic [27:0] w; logic mem; } step_t;
  typedef struct { logic [4:0] op; logic con; int clks; logic [27:0] acc; } vec_t;
  step_t prog[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void push(input logic [27:0] w, input logic mem);
    prog.push_back('{w: w, mem: mem});
  endfunction

  // Expected sequence of control words for one instruction, memory steps flagged.
  function automatic void build(input logic [4:0] op, input logic con);
    prog.delete();
    push(F0W, 1'b1 & 1'b0); push(F1W, 1'b1); push(F2W, 1'b0);
    if (op <= 5'd2) begin
      push(GRB | BAOUT | YIN, 1'b0); push(COUT | ZIN, 1'b0);
      if (op == 5'd1) push(ZLOWOUT | GRA | RIN, 1'b0);
      else begin
        push(ZLOWOUT | MARIN, 1'b0);
        if (op == 5'd0) begin push(READ | MDRIN, 1'b1); push(MDROUT | GRA | RIN, 1'b0); end
        else begin push(GRA | ROUT | MDRIN, 1'b0); push(WRITE, 1'b1); end
      end
    end else if (op <= 5'd11) begin
      push(GRB | ROUT | YIN, 1'b0); push(GRC | ROUT | ZIN, 1'b0); push(GRA | RIN | ZLOWOUT, 1'b0);
    end else if (op <= 5'd14) begin
      push(GRB | ROUT | YIN, 1'b0); push(COUT | ZIN, 1'b0); push(GRA | RIN | ZLOWOUT, 1'b0);
    end else if (op <= 5'd16) begin
      push(GRA | ROUT | YIN, 1'b0);
      for (int i = 0; i < MD_CYCLES; i++) push(GRB | ROUT | ZIN, 1'b0);
      push(LOIN | ZLOWOUT, 1'b0); push(HIIN | ZHIGHOUT, 1'b0);
    end else if (op <= 5'd18) begin
      push(GRB | ROUT | ZIN, 1'b0); push(GRA | RIN | ZLOWOUT, 1'b0);
    end else begin
      case (op)
        5'd19: begin
          push(GRA | ROUT | CONIN, 1'b0);
          if (con) begin push(PCOUT | YIN, 1'b0); push(COUT | ZIN, 1'b0); push(ZLOWOUT | PCIN, 1'b0); end
          else push(28'd0, 1'b0);
        end
        5'd20:   push(GRA | ROUT | PCIN, 1'b0);
        5'd21:   begin push(PCOUT | GRB | RIN, 1'b0); push(GRA | ROUT | PCIN, 1'b0); end
        5'd22:   push(GRA | RIN | INPORTOUT, 1'b0);
        5'd23:   push(GRA | ROUT | OUTPORTIN, 1'b0);
        5'd24:   push(GRA | RIN | HIOUT, 1'b0);
        5'd25:   push(GRA | RIN | LOOUT, 1'b0);
        default: push(28'd0, 1'b0);
      endcase
    end
  endfunction

  task automatic step_clk();
    @(posedge clock);
    @(negedge clock);
  endtask

  // Starts and ends on a falling edge with the DUT expected in F0.
  task automatic run_instr(input logic [4:0] op, input logic con, input bit rnd,
                           input int waits, input bit stp, output int clks);
    build(op, con);
    bus.ir     = {op, 27'($urandom())};
    bus.con_ff = con;
    clks = 0;
    for (int j = 0; j < prog.size(); j++) begin
      int hold;
      bit last;
      last = (j == prog.size() - 1);
      hold = 0;
      if (prog[j].mem) hold = rnd ? int'($urandom_range(0, 4)) : ((j >= 3) ? waits : 0);
      for (int k = 0; k <= hold; k++) begin
        chk($sformatf("op%0d step%0d ctrl", op, j), 32'(bus.ctrl), 32'(prog[j].w));
        chk($sformatf("op%0d step%0d run", op, j), 32'(bus.run), 32'd1);
        bus.mem_ready = prog[j].mem ? (k == hold) : (rnd ? 1'($urandom()) : 1'b1);
        if (rnd) bus.stop = last ? 1'b0 : 1'($urandom());
        else     bus.stop = stp && (j >= prog.size() - 2);
        clks++;
        step_clk();
      end
    end
  endtask

  task automatic measure(input logic [4:0] op, input logic con, output int clks,
                         output logic [27:0] acc);
    bus.ir = {op, 27'($urandom())};
    bus.con_ff = con; bus.mem_ready = 1'b1; bus.stop = 1'b0;
    clks = 0; acc = '0;
    do begin
      if (clks >= 3) acc = acc | bus.ctrl;
      clks++;
      step_clk();
    end while (bus.ctrl != F0W && bus.run && clks < 40);
  endtask

  // Called on a falling edge; clear_n low across one rising edge.
  task automatic do_reset();
    #2 clear_n = 1'b0;
    #1;
    chk("reset ctrl", 32'(bus.ctrl), 32'd0);
    chk("reset run", 32'(bus.run), 32'd0);
    chk("reset err", 32'(bus.err), 32'd0);
    @(negedge clock);
    clear_n = 1'b1; bus.stop = 1'b0; bus.mem_ready = 1'b1;
    #1;
    chk("released idle ctrl", 32'(bus.ctrl), 32'd0);
    @(negedge clock);
    chk("first clock F0 ctrl", 32'(bus.ctrl), 32'(F0W));
    chk("first clock run", 32'(bus.run), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t tbl[15];
    int clks, n;
    logic [27:0] acc;
    tbl[0]  = '{5'd3,  1'b0, 6,  GRB | ROUT | YIN | GRC | ZIN | GRA | RIN | ZLOWOUT};
    tbl[1]  = '{5'd12, 1'b0, 6,  GRB | ROUT | YIN | COUT | ZIN | GRA | RIN | ZLOWOUT};
    tbl[2]  = '{5'd0,  1'b0, 8,  GRB | BAOUT | YIN | COUT | ZIN | ZLOWOUT | MARIN | READ | MDRIN | MDROUT | GRA | RIN};
    tbl[3]  = '{5'd1,  1'b0, 6,  GRB | BAOUT | YIN | COUT | ZIN | ZLOWOUT | GRA | RIN};
    tbl[4]  = '{5'd2,  1'b0, 8,  GRB | BAOUT | YIN | COUT | ZIN | ZLOWOUT | MARIN | GRA | ROUT | MDRIN | WRITE};
    tbl[5]  = '{5'd15, 1'b0, 10, GRA | ROUT | YIN | GRB | ZIN | LOIN | ZLOWOUT | HIIN | ZHIGHOUT};
    tbl[6]  = '{5'd17, 1'b0, 5,  GRB | ROUT | ZIN | GRA | RIN | ZLOWOUT};
    tbl[7]  = '{5'd19, 1'b0, 5,  GRA | ROUT | CONIN};
    tbl[8]  = '{5'd19, 1'b1, 7,  GRA | ROUT | CONIN | PCOUT | YIN | COUT | ZIN | ZLOWOUT | PCIN};
    tbl[9]  = '{5'd20, 1'b0, 4,  GRA | ROUT | PCIN};
    tbl[10] = '{5'd21, 1'b0, 5,  PCOUT | GRB | RIN | GRA | ROUT | PCIN};
    tbl[11] = '{5'd24, 1'b0, 4,  GRA | RIN | HIOUT};
    tbl[12] = '{5'd22, 1'b0, 4,  GRA | RIN | INPORTOUT};
    tbl[13] = '{5'd23, 1'b0, 4,  GRA | ROUT | OUTPORTIN};
    tbl[14] = '{5'd26, 1'b0, 4,  28'd0};

    bus.stop = 1'b0; bus.ir = '0; bus.mem_ready = 1'b1; bus.con_ff = 1'b0;
    clear_n = 1'b0;
    @(negedge clock);
    do_reset();

    for (int i = 0; i < 15; i++) begin
      measure(tbl[i].op, tbl[i].con, clks, acc);
      chk($sformatf("tbl%0d clocks", i), 32'(clks), 32'(tbl[i].clks));
      chk($sformatf("tbl%0d exec ctrl", i), 32'(acc), 32'(tbl[i].acc));
    end

    run_instr(5'd3, 1'b0, 1'b0, 0, 1'b0, clks);
    chk("add clocks", 32'(clks), 32'd6);
    run_instr(5'd0, 1'b0, 1'b0, 3, 1'b0, clks);
    chk("ld wait clocks", 32'(clks), 32'd11);
    run_instr(5'd19, 1'b0, 1'b0, 0, 1'b0, clks);
    chk("br skip clocks", 32'(clks), 32'd5);
    run_instr(5'd19, 1'b1, 1'b0, 0, 1'b0, clks);
    chk("br taken clocks", 32'(clks), 32'd7);
    run_instr(5'd16, 1'b0, 1'b0, 0, 1'b0, clks);
    chk("div clocks", 32'(clks), 32'd10);

    for (int i = 0; i < 60; i++)
      run_instr(5'($urandom_range(0, 26)), 1'($urandom()), 1'b1, 0, 1'b0, clks);
    chk("random stream ends in F0", 32'(bus.ctrl), 32'(F0W));

    run_instr(5'd3, 1'b0, 1'b0, 0, 1'b1, clks);
    chk("stop halt run", 32'(bus.run), 32'd0);
    chk("stop halt ctrl", 32'(bus.ctrl), 32'd0);
    chk("stop halt err", 32'(bus.err), 32'd0);
    bus.stop = 1'b0;
    repeat (3) step_clk();
    chk("halt ignores stop release", 32'(bus.run), 32'd0);
    do_reset();

    bus.ir = {5'd27, 27'($urandom())};
    repeat (3) step_clk();
    chk("halt opcode run", 32'(bus.run), 32'd0);
    chk("halt opcode err", 32'(bus.err), 32'd0);
    do_reset();

    bus.ir = {5'b11101, 27'($urandom())};
    repeat (3) step_clk();
    chk("illegal err", 32'(bus.err), 32'd1);
    chk("illegal run", 32'(bus.run), 32'd0);
    chk("illegal ctrl", 32'(bus.ctrl), 32'd0);
    do_reset();

    bus.ir = {5'd3, 27'd0};
    bus.mem_ready = 1'b0;
    step_clk();
    n = 0;
    while (bus.ctrl == F1W && n < 40) begin
      n++;
      step_clk();
    end
    chk("F1 wait cycles", 32'(n), 32'd16);
    chk("timeout err", 32'(bus.err), 32'd2);
    chk("timeout run", 32'(bus.run), 32'd0);
    chk("timeout ctrl", 32'(bus.ctrl), 32'd0);
    bus.mem_ready = 1'b1;
    repeat (3) step_clk();
    chk("timeout stays halted", 32'(bus.run), 32'd0);
    do_reset();

    bus.ir = {5'd0, 27'($urandom())};
    repeat (6) step_clk();
    chk("ld T6 ctrl", 32'(bus.ctrl), 32'(READ | MDRIN));
    bus.mem_ready = 1'b0;
    step_clk();
    chk("ld T6 held", 32'(bus.ctrl), 32'(READ | MDRIN));
    do_reset();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
